// File: rtl/uart_rx_buffer_pkg.sv
// rtl/uart_rx_buffer_pkg.sv - shared constants for the 8N1 receiver and its byte FIFO
package uart_rx_buffer_pkg;

    localparam int FRAME_BITS           = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 217;  // 25 MHz / 115200 baud

    localparam logic [4:0] ST_IDLE  = 5'b00001;
    localparam logic [4:0] ST_START = 5'b00010;
    localparam logic [4:0] ST_DATA  = 5'b00100;
    localparam logic [4:0] ST_STOP  = 5'b01000;
    localparam logic [4:0] ST_BREAK = 5'b10000;

endpackage

// File: rtl/uart_rx_buffer_byte_fifo.sv
// rtl/uart_rx_buffer_byte_fifo.sv - 2**FIFO_AW deep byte FIFO with combinational head read
module byte_fifo
    import uart_rx_buffer_pkg::*;
#(
    parameter int FIFO_AW = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [FRAME_BITS-1:0] wr_data,
    input  logic                  rd_en,
    output logic [FRAME_BITS-1:0] rd_data,
    output logic                  empty,
    output logic                  full
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};

    logic [FRAME_BITS-1:0] mem_q [DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]      count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_COUNT);
    assign rd_data = mem_q[rd_ptr_q];

    // A full FIFO still accepts a write when the head leaves on the same cycle.
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - 8N1 serial receiver feeding a byte FIFO with valid/ready output
module uart_rx_buffer
    import uart_rx_buffer_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_AW      = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  rx,
    output logic [FRAME_BITS-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  framing_error,
    output logic                  overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(FRAME_BITS - 1);

    logic                  rx_meta_q;
    logic                  rx_s_q;
    logic [4:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_idx_q, bit_idx_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;
    logic                  push;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [FRAME_BITS-1:0] fifo_rd_data;

    always_ff @(posedge clk) begin
        if (clr) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        ferr_d    = 1'b0;
        push      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    // Shift in from the top so the first (LSB) bit ends at bit 0.
                    shreg_d = {rx_s_q, shreg_q[FRAME_BITS-1:1]};
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ovr_d = push && fifo_full && !(ready && !fifo_empty);

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    byte_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .clr     (clr),
        .wr_en   (push),
        .wr_data (shreg_d),
        .rd_en   (ready),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign valid         = !fifo_empty;
    assign data          = fifo_empty ? '0 : fifo_rd_data;
    assign framing_error = ferr_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - randomized self-checking bench with a behavioural receiver/FIFO model
module tb_uart_rx_buffer;

    localparam int CPB   = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int HALF  = CPB / 2;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       framing_error;
    logic       overrun;

    int n_cmp = 0;
    int n_fail = 0;
    int ready_mode = 0;
    bit chk_en = 0;

    logic [7:0] mq[$];
    logic [7:0] mdl_log[$];
    logic [7:0] dut_log[$];
    logic [7:0] exp_seq[$];
    bit   m_s1 = 1'b1;
    bit   m_s2 = 1'b1;
    bit   exp_ferr = 1'b0;
    bit   exp_ovr = 1'b0;
    int   m_ferr_n = 0, m_ovr_n = 0;
    int   dut_ferr_n = 0, dut_ovr_n = 0, dut_valid_cyc = 0;

    uart_rx_buffer #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (AW)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .rx            (rx),
        .data          (data),
        .valid         (valid),
        .ready         (ready),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the reference: synchronizer delay, FIFO push/pop, error pulses.
    task automatic step(input bit push, input logic [7:0] b, input bit ferr, output bit ab);
        bit pop;
        bit was_full;
        @(posedge clk);
        if (clr) begin
            m_s1 = 1'b1;
            m_s2 = 1'b1;
            mq.delete();
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
            ab = 1'b1;
            return;
        end
        ab = 1'b0;
        was_full = (mq.size() == DEPTH);
        pop = (mq.size() != 0) && ready;
        if (pop) begin
            mdl_log.push_back(mq[0]);
            void'(mq.pop_front());
        end
        exp_ovr = 1'b0;
        if (push) begin
            if (!was_full || pop) mq.push_back(b);
            else begin
                exp_ovr = 1'b1;
                m_ovr_n++;
            end
        end
        exp_ferr = ferr;
        if (ferr) m_ferr_n++;
        m_s2 = m_s1;
        m_s1 = rx;
    endtask

    task automatic skip(input int n, output bit ab);
        ab = 1'b0;
        for (int i = 0; i < n && !ab; i++) step(1'b0, 8'h00, 1'b0, ab);
    endtask

    initial begin : model
        bit ab;
        logic [7:0] sh;
        forever begin
            ab = 1'b0;
            while (m_s2) step(1'b0, 8'h00, 1'b0, ab);
            step(1'b0, 8'h00, 1'b0, ab);
            if (ab) continue;
            skip(HALF - 1, ab);
            if (ab) continue;
            if (m_s2) begin
                step(1'b0, 8'h00, 1'b0, ab);
                continue;
            end
            step(1'b0, 8'h00, 1'b0, ab);
            if (ab) continue;
            for (int i = 0; i < 8; i++) begin
                skip(CPB - 1, ab);
                if (ab) break;
                sh[i] = m_s2;
                step(1'b0, 8'h00, 1'b0, ab);
                if (ab) break;
            end
            if (ab) continue;
            skip(CPB - 1, ab);
            if (ab) continue;
            if (m_s2) begin
                step(1'b1, sh, 1'b0, ab);
            end else begin
                step(1'b0, 8'h00, 1'b1, ab);
                if (ab) continue;
                while (!m_s2 && !ab) step(1'b0, 8'h00, 1'b0, ab);
                if (ab) continue;
                step(1'b0, 8'h00, 1'b0, ab);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", valid, (mq.size() != 0));
            if (mq.size() != 0) check("data", data, mq[0]);
            check("framing_error", framing_error, exp_ferr);
            check("overrun", overrun, exp_ovr);
            if (valid && ready) dut_log.push_back(data);
            if (framing_error) dut_ferr_n++;
            if (overrun) dut_ovr_n++;
            if (valid) dut_valid_cyc++;
        end
    end

    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: ready = 1'b0;
            1: ready = 1'b1;
            2: ready = ~ready;
            3: ready = 1'($urandom_range(0, 1));
            default: ready = ($urandom_range(0, 15) == 0);
        endcase
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop_bit, CPB);
    endtask

    task automatic clear_logs();
        dut_log.delete();
        mdl_log.delete();
        m_ferr_n = 0;
        m_ovr_n = 0;
        dut_ferr_n = 0;
        dut_ovr_n = 0;
        dut_valid_cyc = 0;
    endtask

    task automatic check_seq(input string name);
        check({name, "_dut_len"}, dut_log.size(), exp_seq.size());
        check({name, "_mdl_len"}, mdl_log.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size(); i++) begin
            if (i < dut_log.size()) check({name, "_dut_byte"}, dut_log[i], exp_seq[i]);
            if (i < mdl_log.size()) check({name, "_mdl_byte"}, mdl_log[i], exp_seq[i]);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk_en = 1'b1;
        #1;
        check("reset_valid", valid, 1'b0);
        check("reset_data", data, 8'h00);
        check("reset_ferr", framing_error, 1'b0);
        check("reset_ovr", overrun, 1'b0);
        @(posedge clk);
        #1;
        hold(1'b1, 5);

        // single byte, consumer always ready
        clear_logs();
        ready_mode = 1;
        send_frame(8'h41, 1'b1);
        hold(1'b1, 10);
        exp_seq.delete();
        exp_seq.push_back(8'h41);
        check_seq("t1");
        check("t1_valid_cycles", dut_valid_cyc, 1);
        check("t1_ferr_n", dut_ferr_n, 0);
        check("t1_ovr_n", dut_ovr_n, 0);

        // four queued bytes drained by an alternating consumer
        clear_logs();
        ready_mode = 0;
        send_frame(8'h1B, 1'b1);
        send_frame(8'h59, 1'b1);
        send_frame(8'h25, 1'b1);
        send_frame(8'h30, 1'b1);
        hold(1'b1, 6);
        check("t2_valid", valid, 1'b1);
        check("t2_head", data, 8'h1B);
        ready_mode = 2;
        hold(1'b1, 20);
        exp_seq.delete();
        exp_seq.push_back(8'h1B);
        exp_seq.push_back(8'h59);
        exp_seq.push_back(8'h25);
        exp_seq.push_back(8'h30);
        check_seq("t2");
        check("t2_valid_after", valid, 1'b0);

        // overflow by one byte
        clear_logs();
        ready_mode = 0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        hold(1'b1, 6);
        check("t3_ovr_dut", dut_ovr_n, 1);
        check("t3_ovr_mdl", m_ovr_n, 1);
        ready_mode = 2;
        hold(1'b1, 20);
        exp_seq.delete();
        for (int i = 1; i <= 4; i++) exp_seq.push_back(8'(i));
        check_seq("t3");

        // short glitch rejected at the start-bit sample
        clear_logs();
        ready_mode = 1;
        hold(1'b0, 3);
        hold(1'b1, 20);
        exp_seq.delete();
        check_seq("t4");
        check("t4_ferr_n", dut_ferr_n, 0);

        // bad stop bit followed by a held-low line, then a good frame
        clear_logs();
        send_frame(8'h55, 1'b0);
        hold(1'b0, 40);
        hold(1'b1, 10);
        send_frame(8'h7E, 1'b1);
        hold(1'b1, 10);
        check("t5_ferr_dut", dut_ferr_n, 1);
        check("t5_ferr_mdl", m_ferr_n, 1);
        exp_seq.delete();
        exp_seq.push_back(8'h7E);
        check_seq("t5");

        // clear mid-frame with two bytes queued
        clear_logs();
        ready_mode = 0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(1'((8'h33 >> i) & 8'h01), CPB);
        rx = 1'b0;
        hold(1'b0, HALF);
        clr = 1'b1;
        rx = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("t6_valid_after_clr", valid, 1'b0);
        hold(1'b1, 30);
        ready_mode = 1;
        send_frame(8'h20, 1'b1);
        hold(1'b1, 10);
        exp_seq.delete();
        exp_seq.push_back(8'h20);
        check_seq("t6");

        // randomized traffic, consumer pace and line errors
        clear_logs();
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            int kind;
            b = 8'($urandom);
            ready_mode = 3 + int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                send_frame(b, 1'b0);
                hold(1'b0, int'($urandom_range(1, 20)));
                hold(1'b1, int'($urandom_range(1, 12)));
            end else if (kind == 1) begin
                hold(1'b0, int'($urandom_range(1, 3)));
                hold(1'b1, int'($urandom_range(1, 10)));
            end else begin
                send_frame(b, 1'b1);
                hold(1'b1, int'($urandom_range(1, 20)));
            end
        end
        ready_mode = 1;
        hold(1'b1, 40);
        check("rand_log_len", dut_log.size(), mdl_log.size());
        check("rand_ferr_n", dut_ferr_n, m_ferr_n);
        check("rand_ovr_n", dut_ovr_n, m_ovr_n);
        check("rand_drained", valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
